// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin sharing of one pipelined multiplier among NUM_REQ requesters
// Each requester owns at most one op; tags ride alongside the multiplier and steer products home.
module mult_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LEN    = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [NUM_REQ*DATA_LEN-1:0]  rsp_result,
  output logic [DATA_LEN-1:0]          mul_a,
  output logic [DATA_LEN-1:0]          mul_b,
  input  logic [DATA_LEN-1:0]          mul_result,
  output logic                         busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } req_state_e;

  req_state_e                      state_q [NUM_REQ];
  req_state_e                      state_d [NUM_REQ];
  logic [IDW-1:0]                  last_grant_q, last_grant_d;
  logic [MUL_LATENCY:0]            tag_v_q, tag_v_d;
  logic [MUL_LATENCY:0][IDW-1:0]   tag_id_q, tag_id_d;
  logic [DATA_LEN-1:0]             mul_a_q, mul_a_d;
  logic [DATA_LEN-1:0]             mul_b_q, mul_b_d;
  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_LEN-1:0]     rsp_result_q, rsp_result_d;
  logic                            busy_q, busy_d;

  logic [NUM_REQ-1:0]              eligible;
  logic                            grant_valid;
  logic [IDW-1:0]                  grant_id;
  logic [IDW:0]                    idx_w;
  logic                            tail_v;
  logic [IDW-1:0]                  tail_id;

  assign tail_v  = tag_v_q[MUL_LATENCY];
  assign tail_id = tag_id_q[MUL_LATENCY];

  // Gating with reset_n keeps req_ready low for the whole reset assertion.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (state_q[i] == ST_IDLE) && !flush && reset_n;
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx_w       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_w = {1'b0, last_grant_q} + (IDW+1)'(off);
      if (idx_w >= (IDW+1)'(NUM_REQ)) begin
        idx_w = idx_w - (IDW+1)'(NUM_REQ);
      end
      if (!grant_valid && eligible[idx_w[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = idx_w[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = grant_valid ? grant_id : last_grant_q;
    mul_a_d      = '0;
    mul_b_d      = '0;
    if (grant_valid) begin
      mul_a_d = req_a[grant_id*DATA_LEN +: DATA_LEN];
      mul_b_d = req_b[grant_id*DATA_LEN +: DATA_LEN];
    end

    tag_v_d[0]  = grant_valid;
    tag_id_d[0] = grant_id;
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end

    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE:   if (grant_valid && grant_id == IDW'(i)) state_d[i] = ST_ISSUED;
        ST_ISSUED: if (tail_v && tail_id == IDW'(i)) state_d[i] = ST_DONE;
        ST_DONE:   if (rsp_valid_q[i] && rsp_ready[i]) state_d[i] = ST_IDLE;
        default:   state_d[i] = ST_IDLE;
      endcase
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end

    // One-outstanding rule guarantees the tail never lands on a slot being consumed.
    if (tail_v && !flush) begin
      rsp_valid_d[tail_id] = 1'b1;
      rsp_result_d[tail_id*DATA_LEN +: DATA_LEN] = mul_result;
    end

    if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_d[i] = ST_IDLE;
      end
      tag_v_d     = '0;
      rsp_valid_d = '0;
      mul_a_d     = '0;
      mul_b_d     = '0;
    end

    busy_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_d[i] != ST_IDLE) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= ST_IDLE;
      end
      last_grant_q <= IDW'(NUM_REQ - 1);
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= state_d[i];
      end
      last_grant_q <= last_grant_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      busy_q       <= busy_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - self-checking bench for mult_rr_scheduler
// Transaction-level model (per-requester countdown to response) checked every cycle.
module tb_mult_rr_scheduler;
  localparam int N  = 4;
  localparam int DL = 32;
  localparam int L  = 2;
  localparam int W  = N * DL;
  typedef logic [W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready = '0;
  logic [W-1:0] rsp_result;
  logic [DL-1:0] mul_a, mul_b, mul_result;
  logic         busy;

  int tests = 0;
  int fails = 0;

  initial forever #5 clk = ~clk;

  mult_rr_scheduler #(.NUM_REQ(N), .DATA_LEN(DL), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .busy(busy)
  );

  // Environment multiplier: L register stages, not stallable, not reset.
  logic [DL-1:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= mul_a * mul_b;
    for (int j = 1; j < L; j++) mpipe[j] <= mpipe[j-1];
  end
  assign mul_result = mpipe[L-1];

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns an op, how many edges until its product shows up, what it is.
  bit            m_busy [N];
  int            m_cnt  [N];
  logic [DL-1:0] m_prod [N];
  logic [DL-1:0] m_rres [N];
  bit            m_rv   [N];
  int            m_lg;
  logic [DL-1:0] m_mula, m_mulb;
  bit            log_en = 1'b0;
  int            grant_log[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_cnt[i] = 0; m_prod[i] = '0; m_rres[i] = '0; m_rv[i] = 1'b0;
    end
    m_lg = N - 1; m_mula = '0; m_mulb = '0;
  endtask

  always @(negedge clk) begin : cmp
    int g, idx;
    logic [N-1:0] exp_ready, exp_rv;
    vec_t exp_res;
    bit exp_busy;
    if (!reset_n) model_reset();
    g = -1;
    if (reset_n && !flush) begin
      for (int off = 1; off <= N; off++) begin
        idx = (m_lg + off) % N;
        if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv = '0; exp_res = '0; exp_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_rv[i] = m_rv[i];
      exp_res[i*DL +: DL] = m_rres[i];
      if (m_busy[i]) exp_busy = 1'b1;
    end
    chk("req_ready",  vec_t'(req_ready),  vec_t'(exp_ready));
    chk("mul_a",      vec_t'(mul_a),      vec_t'(m_mula));
    chk("mul_b",      vec_t'(mul_b),      vec_t'(m_mulb));
    chk("rsp_valid",  vec_t'(rsp_valid),  vec_t'(exp_rv));
    chk("rsp_result", rsp_result,         exp_res);
    chk("busy",       vec_t'(busy),       vec_t'(exp_busy));
    if (log_en) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
    end
    if (reset_n) begin
      if (flush) begin
        for (int i = 0; i < N; i++) begin m_busy[i] = 1'b0; m_cnt[i] = 0; m_rv[i] = 1'b0; end
        m_mula = '0; m_mulb = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_rv[i] && rsp_ready[i]) begin m_rv[i] = 1'b0; m_busy[i] = 1'b0; end
          if (m_cnt[i] > 0) begin
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin m_rv[i] = 1'b1; m_rres[i] = m_prod[i]; end
          end
        end
        if (g >= 0) begin
          m_busy[g] = 1'b1;
          m_cnt[g]  = L + 1;
          m_mula    = req_a[g*DL +: DL];
          m_mulb    = req_b[g*DL +: DL];
          m_prod[g] = m_mula * m_mulb;
          m_lg      = g;
        end else begin
          m_mula = '0; m_mulb = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DL-1:0] a, input logic [DL-1:0] b);
    req_a[i*DL +: DL] = a;
    req_b[i*DL +: DL] = b;
  endtask

  initial begin
    int c1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mul_a", vec_t'(mul_a), vec_t'(0));
    chk("rst_busy",  vec_t'(busy),  vec_t'(0));
    chk("rst_ready", vec_t'(req_ready), vec_t'(0));
    reset_n = 1'b1;

    // Single op: 7*6 on requester 0
    set_op(0, 32'd7, 32'd6);
    req_valid = 4'b0001;
    #1 chk("t1_ready", vec_t'(req_ready), vec_t'(4'b0001));
    tick();
    req_valid = '0;
    chk("t1_mul_a", vec_t'(mul_a), vec_t'(7));
    chk("t1_mul_b", vec_t'(mul_b), vec_t'(6));
    chk("t1_busy",  vec_t'(busy),  vec_t'(1));
    tick(); tick();
    chk("t1_early", vec_t'(rsp_valid), vec_t'(0));
    tick();
    chk("t1_rsp_valid", vec_t'(rsp_valid), vec_t'(4'b0001));
    chk("t1_result", vec_t'(rsp_result[0 +: DL]), vec_t'(42));
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    chk("t1_busy_fall", vec_t'(busy), vec_t'(0));
    chk("t1_consumed", vec_t'(rsp_valid), vec_t'(0));
    chk("t1_hold", vec_t'(rsp_result[0 +: DL]), vec_t'(42));

    // Fairness: last grant was 0, so the rotation starts at 1
    for (int i = 0; i < N; i++) set_op(i, DL'(i + 3), DL'(100 * i + 11));
    grant_log.delete();
    log_en = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    repeat (20) tick();
    log_en = 1'b0;
    req_valid = '0;
    repeat (6) tick();
    rsp_ready = '0;
    chk("fair_count", vec_t'(grant_log.size() >= 8), vec_t'(1));
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("fair_order", vec_t'(grant_log[k]), vec_t'((k + 1) % N));
    chk("fair_drain", vec_t'(busy), vec_t'(0));

    // Back-to-back: 3*5 on req1, then 0xFFFFFFFF*2 on req2
    set_op(1, 32'd3, 32'd5);
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0010;
    #1 chk("b2b_ready1", vec_t'(req_ready), vec_t'(4'b0010));
    tick();
    req_valid = 4'b0100;
    #1 chk("b2b_ready2", vec_t'(req_ready), vec_t'(4'b0100));
    tick();
    req_valid = '0;
    tick(); tick();
    chk("b2b_rv1", vec_t'(rsp_valid), vec_t'(4'b0010));
    chk("b2b_res1", vec_t'(rsp_result[1*DL +: DL]), vec_t'(15));
    tick();
    chk("b2b_rv2", vec_t'(rsp_valid), vec_t'(4'b0110));
    chk("b2b_res2", vec_t'(rsp_result[2*DL +: DL]), vec_t'(32'hFFFF_FFFE));
    rsp_ready = 4'b0110;
    tick();
    rsp_ready = '0;

    // Backpressure on requester 0
    set_op(0, 32'd2, 32'd21);
    set_op(1, 32'd4, 32'd4);
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    #1 chk("bp_first", vec_t'(req_ready), vec_t'(4'b0001));
    tick();
    req_valid = 4'b0011;
    grant_log.delete();
    log_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1 chk("bp_blocked", vec_t'(req_ready[0]), vec_t'(0));
      tick();
    end
    log_en = 1'b0;
    c1 = 0;
    foreach (grant_log[k]) if (grant_log[k] == 1) c1++;
    chk("bp_others", vec_t'(c1 >= 2), vec_t'(1));
    chk("bp_held", vec_t'(rsp_result[0 +: DL]), vec_t'(42));
    rsp_ready = 4'b1111;
    #1 chk("bp_consume_cycle", vec_t'(req_ready[0]), vec_t'(0));
    tick();
    rsp_ready = 4'b1110;
    #1 chk("bp_regrant", vec_t'(req_ready), vec_t'(4'b0001));
    tick();
    req_valid = '0;
    rsp_ready = 4'b1111;
    repeat (8) tick();
    rsp_ready = '0;
    chk("bp_drain", vec_t'(busy), vec_t'(0));

    // Flush with two ops in flight, then 9*9 on req3
    set_op(1, 32'd5, 32'd5);
    set_op(2, 32'd6, 32'd6);
    set_op(3, 32'd9, 32'd9);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1000;
    flush = 1'b1;
    #1 chk("fl_ready", vec_t'(req_ready), vec_t'(0));
    tick();
    flush = 1'b0;
    chk("fl_mul_a", vec_t'(mul_a), vec_t'(0));
    chk("fl_busy", vec_t'(busy), vec_t'(0));
    #1 chk("fl_ready3", vec_t'(req_ready), vec_t'(4'b1000));
    tick();
    req_valid = '0;
    chk("fl_issue3", vec_t'(mul_a), vec_t'(9));
    tick();
    chk("fl_quiet1", vec_t'(rsp_valid), vec_t'(0));
    tick();
    chk("fl_quiet2", vec_t'(rsp_valid), vec_t'(0));
    tick();
    chk("fl_rv3", vec_t'(rsp_valid), vec_t'(4'b1000));
    chk("fl_res3", vec_t'(rsp_result[3*DL +: DL]), vec_t'(81));
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = '0;

    // Asynchronous reset between edges with two ops in flight
    set_op(0, 32'd11, 32'd3);
    set_op(1, 32'd12, 32'd3);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1111;
    #2 reset_n = 1'b0;
    #1;
    chk("ar_mul_a", vec_t'(mul_a), vec_t'(0));
    chk("ar_mul_b", vec_t'(mul_b), vec_t'(0));
    chk("ar_busy", vec_t'(busy), vec_t'(0));
    chk("ar_rsp_valid", vec_t'(rsp_valid), vec_t'(0));
    chk("ar_rsp_result", rsp_result, vec_t'(0));
    chk("ar_ready", vec_t'(req_ready), vec_t'(0));
    tick();
    reset_n = 1'b1;
    #1 chk("ar_first_grant", vec_t'(req_ready), vec_t'(4'b0001));
    tick();
    req_valid = '0;
    tick();
    chk("ar_no_stale1", vec_t'(rsp_valid), vec_t'(0));
    tick();
    chk("ar_no_stale2", vec_t'(rsp_valid), vec_t'(0));
    tick();
    chk("ar_rv0", vec_t'(rsp_valid), vec_t'(4'b0001));
    chk("ar_res0", vec_t'(rsp_result[0 +: DL]), vec_t'(33));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
